seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a bank of common-cathode 7-segment digits that share one hex-to-segment decoder. Holds one 4-bit hex code plus an enable bit per digit. Walks the digits round-robin, driving the shared decoder's 4-bit data input and a one-hot digit select, with dead (blank) cycles between digits to suppress ghosting. Sits between the register/control logic that writes display values and the combinational segment decoder feeding the LED pins.

---
 rtl/seg_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Round-robin scan controller for a bank of multiplexed 7-segment digits sharing one decoder.
// Inserts blank cycles between digit windows and shadows each digit's value for its whole window.
module seg_scan_ctrl #(
    parameter int NDIG  = 4,
    parameter int DIV   = 1000,
    parameter int BLANK = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            scan_en,
    input  logic            wr_en,
    input  logic [2:0]      wr_addr,
    input  logic [4:0]      wr_data,
    output logic [3:0]      digit_code,
    output logic [NDIG-1:0] dig_sel,
    output logic            frame_tick
);

    localparam int CNT_MAX = (DIV > BLANK) ? DIV : BLANK;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(NDIG);

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic       en;
        logic [3:0] code;
    } entry_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    entry_t            entry_q [NDIG];
    entry_t            entry_d [NDIG];
    logic [3:0]        code_q, code_d;
    logic [NDIG-1:0]   dig_sel_q, dig_sel_d;
    logic              frame_tick_q, frame_tick_d;

    entry_t            cur_entry;
    logic [NDIG-1:0]   cur_one_hot;

    assign cur_entry   = entry_q[idx_q];
    assign cur_one_hot = NDIG'(1) << idx_q;

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        code_d       = code_q;
        dig_sel_d    = dig_sel_q;
        frame_tick_d = 1'b0;
        entry_d      = entry_q;

        if (wr_en && (int'(wr_addr) < NDIG)) begin
            entry_d[wr_addr[IDX_W-1:0]] = entry_t'(wr_data);
        end

        if (!scan_en) begin
            state_d   = S_BLANK;
            cnt_d     = '0;
            dig_sel_d = '0;
        end else begin
            case (state_q)
                S_BLANK: begin
                    if (cnt_q == CNT_W'(BLANK - 1)) begin
                        // Capture from the registered entry: a write on this same edge is not seen.
                        state_d   = S_DRIVE;
                        cnt_d     = '0;
                        code_d    = cur_entry.code;
                        dig_sel_d = cur_entry.en ? cur_one_hot : '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == CNT_W'(DIV - 1)) begin
                        state_d   = S_BLANK;
                        cnt_d     = '0;
                        dig_sel_d = '0;
                        if (idx_q == IDX_W'(NDIG - 1)) begin
                            idx_d        = '0;
                            frame_tick_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // NOTE: the entry bank is a handful of flops rather than a RAM, so it is cleared in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            code_q       <= '0;
            dig_sel_q    <= '0;
            frame_tick_q <= 1'b0;
            for (int i = 0; i < NDIG; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            code_q       <= code_d;
            dig_sel_q    <= dig_sel_d;
            frame_tick_q <= frame_tick_d;
            entry_q      <= entry_d;
        end
    end

    assign digit_code = code_q;
    assign dig_sel    = dig_sel_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: a slot-position reference model pushes per-cycle
// expectations into a scoreboard queue, which is popped and compared on the falling edge.
module tb_seg_scan_ctrl;

    localparam int NDIG  = 4;
    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int SLOT  = BLANK + DIV;
    localparam int FRAME = NDIG * SLOT;

    logic            clk;
    logic            rst_n;
    logic            scan_en;
    logic            wr_en;
    logic [2:0]      wr_addr;
    logic [4:0]      wr_data;
    logic [3:0]      digit_code;
    logic [NDIG-1:0] dig_sel;
    logic            frame_tick;

    seg_scan_ctrl #(
        .NDIG (NDIG),
        .DIV  (DIV),
        .BLANK(BLANK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_en   (scan_en),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .digit_code(digit_code),
        .dig_sel   (dig_sel),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NDIG-1:0] sel;
        logic [3:0]      code;
        logic            tick;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: position inside the frame plus the entry image it has been told about.
    logic            m_en   [NDIG];
    logic [3:0]      m_code [NDIG];
    int              m_pos;
    logic [NDIG-1:0] m_sel;
    logic [3:0]      m_dcode;
    logic            m_tick;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NDIG; i++) begin
            m_en[i]   = 1'b0;
            m_code[i] = 4'h0;
        end
        m_pos   = 0;
        m_sel   = '0;
        m_dcode = 4'h0;
        m_tick  = 1'b0;
    endtask

    // Advances the model by one clock edge using the inputs driven during the current cycle.
    task automatic model_advance();
        int k;
        int ph;
        int npos;
        logic [NDIG-1:0] one;
        if (!rst_n) begin
            model_reset();
            return;
        end
        k   = m_pos / SLOT;
        ph  = m_pos % SLOT;
        one = 1;
        if (!scan_en) begin
            m_pos  = k * SLOT;
            m_sel  = '0;
            m_tick = 1'b0;
        end else begin
            npos   = (m_pos + 1) % FRAME;
            m_tick = (npos == 0);
            if (ph == BLANK - 1) begin
                m_dcode = m_code[k];
                m_sel   = m_en[k] ? (one << k) : '0;
            end else if ((npos % SLOT) == 0) begin
                m_sel = '0;
            end
            m_pos = npos;
        end
        if (wr_en && (int'(wr_addr) < NDIG)) begin
            m_en[int'(wr_addr)]   = wr_data[4];
            m_code[int'(wr_addr)] = wr_data[3:0];
        end
    endtask

    task automatic step(input logic r, input logic e, input logic we,
                        input logic [2:0] a, input logic [4:0] d);
        exp_t want;
        exp_t got_exp;
        rst_n   = r;
        scan_en = e;
        wr_en   = we;
        wr_addr = a;
        wr_data = d;
        want.sel  = m_sel;
        want.code = m_dcode;
        want.tick = m_tick;
        sb_q.push_back(want);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check($sformatf("scoreboard_empty@%0d", cyc), 32'd0, 32'd1);
        end else begin
            got_exp = sb_q.pop_front();
            check($sformatf("dig_sel@%0d", cyc), 32'(dig_sel), 32'(got_exp.sel));
            check($sformatf("digit_code@%0d", cyc), 32'(digit_code), 32'(got_exp.code));
            check($sformatf("frame_tick@%0d", cyc), 32'(frame_tick), 32'(got_exp.tick));
            check($sformatf("onehot@%0d", cyc), 32'($countones(dig_sel) <= 1), 32'd1);
        end
        model_advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic       r;
        logic       en;
        logic       we;
        logic [2:0] a;
        logic [4:0] d;

        rst_n   = 1'b0;
        scan_en = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 3'd0;
        wr_data = 5'h00;
        model_reset();
        @(posedge clk);
        #1;

        // Reset held with write strobes: nothing may land in the bank.
        step(1'b0, 1'b1, 1'b1, 3'd0, 5'h1E);
        step(1'b0, 1'b1, 1'b0, 3'd0, 5'h00);
        step(1'b0, 1'b1, 1'b1, 3'd3, 5'h1F);

        // Idle scan with an empty bank: no selects, ticks at cycles 20 and 40.
        cyc = 0;
        for (int i = 0; i < 41; i++) begin
            step(1'b1, 1'b1, 1'b0, 3'd0, 5'h00);
        end

        // Load the bank while scanning is held off, including out-of-range addresses.
        step(1'b1, 1'b0, 1'b1, 3'd0, 5'h13);
        step(1'b1, 1'b0, 1'b1, 3'd1, 5'h17);
        step(1'b1, 1'b0, 1'b1, 3'd2, 5'h1A);
        step(1'b1, 1'b0, 1'b1, 3'd3, 5'h1F);
        step(1'b1, 1'b0, 1'b1, 3'd5, 5'h1B);
        step(1'b1, 1'b0, 1'b1, 3'd7, 5'h12);
        step(1'b1, 1'b0, 1'b0, 3'd0, 5'h00);

        // Main scan: mid-window write, capture-edge write, disabled digit, pause, mid-run reset.
        cyc = 0;
        for (int c = 0; c < 146; c++) begin
            r  = 1'b1;
            en = 1'b1;
            we = 1'b0;
            a  = 3'd0;
            d  = 5'h00;
            case (c)
                7:   begin we = 1'b1; a = 3'd1; d = 5'h19; end
                20:  begin we = 1'b1; a = 3'd0; d = 5'h1C; end
                25:  begin we = 1'b1; a = 3'd2; d = 5'h05; end
                55:  begin we = 1'b1; a = 3'd2; d = 5'h16; end
                90:  begin we = 1'b1; a = 3'd6; d = 5'h10; end
                118: r = 1'b0;
                default: ;
            endcase
            if (c >= 72 && c <= 74) en = 1'b0;
            step(r, en, we, a, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
